// File: rtl/sc_stage_scheduler.sv
// -----------------------------------------------------------------------------
// sc_stage_scheduler
//
// Control FSM that sequences a semi-parallel successive-cancellation decoder
// over one codeword of N = 2^N_LOG bits. Each RUN cycle issues one PE-array
// operation: a stage, an f/g selection and a PE block within that stage. The
// scheduler also tracks the current bit index and flags the cycle in which the
// leaf LLR is valid so that the bit decision can be taken.
//
// Optional feature macro: SCHED_STALL_EN
//   When defined, adds the 'stall' input. A stall in RUN holds every piece of
//   schedule state and suppresses pe_en and bit_valid for that cycle.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin one codeword; sampled in IDLE only
//   stall        in   (SCHED_STALL_EN only) freeze the schedule for one cycle
//   busy         out  high while in RUN
//   done         out  one-cycle pulse after the last bit decision
//   pe_en        out  PE array computes this cycle
//   stage_index  out  stage being computed (N_LOG-1 = channel side, 0 = leaf)
//   fg_sel       out  0 = f function, 1 = g function
//   pe_block     out  PE chunk within the current stage
//   bit_index    out  index of the bit currently being decoded
//   bit_valid    out  leaf LLR valid this cycle; a bit decision is taken
// -----------------------------------------------------------------------------
module sc_stage_scheduler #(
    parameter int unsigned N_LOG   = 3,
    parameter int unsigned P_LOG   = 0,
    parameter int unsigned STAGE_W = ($clog2(N_LOG) > 1) ? $clog2(N_LOG) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
`ifdef SCHED_STALL_EN
    input  logic                stall,
`endif
    output logic                busy,
    output logic                done,
    output logic                pe_en,
    output logic [STAGE_W-1:0]  stage_index,
    output logic                fg_sel,
    output logic [((N_LOG > P_LOG + 1) ? (N_LOG - 1 - P_LOG) : 1)-1:0] pe_block,
    output logic [N_LOG-1:0]    bit_index,
    output logic                bit_valid
);

    localparam int unsigned BLK_W = (N_LOG > P_LOG + 1) ? (N_LOG - 1 - P_LOG) : 1;
    localparam int          PL    = int'(P_LOG);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic               fg_q, fg_d;
    logic [BLK_W-1:0]   block_q, block_d;
    logic [N_LOG-1:0]   bit_q, bit_d;

    logic               stall_w;
    logic               run_ok;
    logic               last_block;
    logic [N_LOG-1:0]   next_bit;
    logic [STAGE_W-1:0] ctz_stage;

`ifdef SCHED_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    assign run_ok = (state_q == StRun) && !stall_w;

    // Stages at or below P_LOG fit in a single PE pass; wider stages take
    // 2^(stage-P_LOG) passes.
    always_comb begin
        last_block = 1'b1;
        if (int'(stage_q) > PL) begin
            last_block = (int'(block_q) == ((1 << (int'(stage_q) - PL)) - 1));
        end
    end

    // After bit i is decided, decoding of bit i+1 resumes at stage ctz(i+1)
    // with a g operation. Scanning from the MSB down leaves the lowest set bit.
    assign next_bit = bit_q + 1'b1;

    always_comb begin
        ctz_stage = '0;
        for (int i = int'(N_LOG) - 1; i >= 0; i--) begin
            if (next_bit[i]) begin
                ctz_stage = STAGE_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        fg_d    = fg_q;
        block_d = block_q;
        bit_d   = bit_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    stage_d = STAGE_W'(N_LOG - 1);
                    fg_d    = 1'b0;
                    block_d = '0;
                    bit_d   = '0;
                end
            end
            StRun: begin
                if (run_ok) begin
                    if (!last_block) begin
                        block_d = block_q + 1'b1;
                    end else if (stage_q != '0) begin
                        stage_d = stage_q - 1'b1;
                        fg_d    = 1'b0;
                        block_d = '0;
                    end else if (&bit_q) begin
                        // Last bit: clear the schedule so DONE/IDLE show zeros.
                        state_d = StDone;
                        stage_d = '0;
                        fg_d    = 1'b0;
                        block_d = '0;
                        bit_d   = '0;
                    end else begin
                        bit_d   = next_bit;
                        stage_d = ctz_stage;
                        fg_d    = 1'b1;
                        block_d = '0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            stage_q <= '0;
            fg_q    <= 1'b0;
            block_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            fg_q    <= fg_d;
            block_q <= block_d;
            bit_q   <= bit_d;
        end
    end

    // Schedule registers are zero outside RUN, so they drive the ports directly.
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign pe_en       = run_ok;
    assign stage_index = stage_q;
    assign fg_sel      = fg_q;
    assign pe_block    = block_q;
    assign bit_index   = bit_q;
    assign bit_valid   = run_ok && (stage_q == '0) && last_block;

endmodule

// File: tb/tb_sc_stage_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for sc_stage_scheduler.
// dut0: N_LOG=3, P_LOG=0, checked cycle by cycle against a tree-traversal model.
// dut2: N_LOG=3, P_LOG=2, checked against a fixed vector table.
// -----------------------------------------------------------------------------
module tb_sc_stage_scheduler;

    logic       clk;
    logic       rst_n;
    logic       start0, start2;
`ifdef SCHED_STALL_EN
    logic       stall0, stall2;
`endif

    logic       busy0, done0, pe_en0, fg0, bv0;
    logic [1:0] stage0;
    logic [1:0] blk0;
    logic [2:0] bit0;

    logic       busy2, done2, pe_en2, fg2, bv2;
    logic [1:0] stage2;
    logic [0:0] blk2;
    logic [2:0] bit2;

    int checks = 0;
    int errors = 0;

    sc_stage_scheduler #(.N_LOG(3), .P_LOG(0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start0),
`ifdef SCHED_STALL_EN
        .stall       (stall0),
`endif
        .busy        (busy0),
        .done        (done0),
        .pe_en       (pe_en0),
        .stage_index (stage0),
        .fg_sel      (fg0),
        .pe_block    (blk0),
        .bit_index   (bit0),
        .bit_valid   (bv0)
    );

    sc_stage_scheduler #(.N_LOG(3), .P_LOG(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start2),
`ifdef SCHED_STALL_EN
        .stall       (stall2),
`endif
        .busy        (busy2),
        .done        (done2),
        .pe_en       (pe_en2),
        .stage_index (stage2),
        .fg_sel      (fg2),
        .pe_block    (blk2),
        .bit_index   (bit2),
        .bit_valid   (bv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int stage;
        int fg;
        int blk;
        int bv;
        int bidx;
    } sched_t;

    typedef struct {
        bit start;
        int stage;
        int fg;
        int bv;
        int bidx;
    } vec_t;

    sched_t exp_q[$];
    vec_t   tbl[14];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int blocks(input int s, input int p_log);
        return (s > p_log) ? (1 << (s - p_log)) : 1;
    endfunction

    // Stage s is visited once per node at that depth, twice (f and g) each.
    function automatic int run_cycles(input int n_log, input int p_log);
        int sum = 0;
        for (int s = 0; s < n_log; s++) sum += (1 << (n_log - s)) * blocks(s, p_log);
        return sum;
    endfunction

    // Depth-first SC tree walk with an explicit stack: visiting a node at
    // stage s emits f(s), decodes the left child, emits g(s), decodes the
    // right child. Stage-0 operations feed a leaf decision.
    task automatic build_sched(input int n_log, input int p_log);
        int stack[$];
        int item, s, g, nb, leaves;
        sched_t e;
        exp_q.delete();
        leaves = 0;
        stack.push_back((n_log - 1) * 2);
        while (stack.size() > 0) begin
            item = stack.pop_back();
            s = item / 2;
            g = item % 2;
            nb = blocks(s, p_log);
            for (int b = 0; b < nb; b++) begin
                e.stage = s;
                e.fg    = g;
                e.blk   = b;
                e.bv    = (s == 0 && b == nb - 1) ? 1 : 0;
                e.bidx  = leaves;
                exp_q.push_back(e);
            end
            if (s == 0) leaves++;
            if (g == 0) stack.push_back(s * 2 + 1);
            if (s > 0) stack.push_back((s - 1) * 2);
        end
    endtask

    task automatic chk_idle0(input string tag);
        chk({tag, ".busy"}, int'(busy0), 0);
        chk({tag, ".done"}, int'(done0), 0);
        chk({tag, ".pe_en"}, int'(pe_en0), 0);
        chk({tag, ".stage"}, int'(stage0), 0);
        chk({tag, ".fg"}, int'(fg0), 0);
        chk({tag, ".blk"}, int'(blk0), 0);
        chk({tag, ".bit"}, int'(bit0), 0);
        chk({tag, ".bv"}, int'(bv0), 0);
    endtask

    // One codeword on dut0 with random start noise during RUN/DONE.
    task automatic run_codeword(input int gap, input int stall_len);
        int cyc, n_pe, n_bv;
        bit stalled;
        start0 = 1'b0;
        for (int i = 0; i < gap; i++) begin
            tick();
            chk_idle0("gap");
        end
        start0 = 1'b1;
        cyc = 0; n_pe = 0; n_bv = 0; stalled = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            tick();
            cyc++;
            start0 = 1'($urandom_range(0, 1));
`ifdef SCHED_STALL_EN
            if (!stalled && stall_len > 0 && exp_q[k].bidx == 4) begin
                stalled = 1'b1;
                for (int j = 0; j < stall_len; j++) begin
                    stall0 = 1'b1;
                    #1;
                    chk("stall.pe_en", int'(pe_en0), 0);
                    chk("stall.bv", int'(bv0), 0);
                    chk("stall.busy", int'(busy0), 1);
                    chk("stall.stage", int'(stage0), exp_q[k].stage);
                    chk("stall.bit", int'(bit0), 4);
                    tick();
                    cyc++;
                end
                stall0 = 1'b0;
            end
`endif
            #1;
            chk("run.busy", int'(busy0), 1);
            chk("run.pe_en", int'(pe_en0), 1);
            chk("run.done", int'(done0), 0);
            chk("run.stage", int'(stage0), exp_q[k].stage);
            chk("run.fg", int'(fg0), exp_q[k].fg);
            chk("run.blk", int'(blk0), exp_q[k].blk);
            chk("run.bv", int'(bv0), exp_q[k].bv);
            chk("run.bit", int'(bit0), exp_q[k].bidx);
            if (pe_en0) n_pe++;
            if (bv0) n_bv++;
        end
        tick();
        cyc++;
        chk("done.pulse", int'(done0), 1);
        chk("done.busy", int'(busy0), 0);
        chk("done.pe_en", int'(pe_en0), 0);
        chk("latency", cyc, run_cycles(3, 0) + 1 + stall_len);
        chk("pe_en.count", n_pe, run_cycles(3, 0));
        chk("bv.count", n_bv, 8);
        start0 = 1'b1;  // must be ignored in DONE
        tick();
        start0 = 1'b0;
        chk_idle0("post");
    endtask

    initial begin
        tbl[0]  = '{1'b0, 2, 0, 0, 0};
        tbl[1]  = '{1'b1, 1, 0, 0, 0};
        tbl[2]  = '{1'b0, 0, 0, 1, 0};
        tbl[3]  = '{1'b1, 0, 1, 1, 1};
        tbl[4]  = '{1'b0, 1, 1, 0, 2};
        tbl[5]  = '{1'b0, 0, 0, 1, 2};
        tbl[6]  = '{1'b1, 0, 1, 1, 3};
        tbl[7]  = '{1'b0, 2, 1, 0, 4};
        tbl[8]  = '{1'b0, 1, 0, 0, 4};
        tbl[9]  = '{1'b1, 0, 0, 1, 4};
        tbl[10] = '{1'b0, 0, 1, 1, 5};
        tbl[11] = '{1'b0, 1, 1, 0, 6};
        tbl[12] = '{1'b1, 0, 0, 1, 6};
        tbl[13] = '{1'b1, 0, 1, 1, 7};

        rst_n  = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
`ifdef SCHED_STALL_EN
        stall0 = 1'b0;
        stall2 = 1'b0;
`endif
        #12;
        chk_idle0("reset");
        chk("reset.busy2", int'(busy2), 0);
        chk("reset.done2", int'(done2), 0);
        rst_n = 1'b1;
        tick();
        chk_idle0("idle");

        // Start pulsed while the other DUT is idle: no spurious activity.
        chk("idle.busy2", int'(busy2), 0);

        // dut2 (P_LOG=2) against the fixed (stage, fg) vector table.
        start2 = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            start2 = tbl[k].start;
            #1;
            chk("tbl.busy", int'(busy2), 1);
            chk("tbl.pe_en", int'(pe_en2), 1);
            chk("tbl.stage", int'(stage2), tbl[k].stage);
            chk("tbl.fg", int'(fg2), tbl[k].fg);
            chk("tbl.blk", int'(blk2), 0);
            chk("tbl.bv", int'(bv2), tbl[k].bv);
            chk("tbl.bit", int'(bit2), tbl[k].bidx);
        end
        tick();
        start2 = 1'b1;
        chk("tbl.done", int'(done2), 1);
        chk("tbl.done_busy", int'(busy2), 0);
        tick();
        start2 = 1'b0;
        chk("tbl.after_done", int'(done2), 0);
        chk("tbl.after_busy", int'(busy2), 0);
        chk("tbl.after_bit", int'(bit2), 0);

        // dut0 against the tree-walk model, randomized gaps and start noise.
        build_sched(3, 0);
        for (int r = 0; r < 6; r++) begin
            run_codeword(int'($urandom_range(0, 3)), 0);
        end

        // Asynchronous reset at RUN cycle 10.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("pre_rst.busy", int'(busy0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle0("async_rst");
        tick();
        chk_idle0("rst_hold");
        #2;
        rst_n = 1'b1;
        run_codeword(1, 0);

`ifdef SCHED_STALL_EN
        run_codeword(1, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
